// File: rtl/axis_frame_len_check_pkg.sv
// Shared types and helpers for the AXI-Stream frame length checker.
//   state_t        : checker FSM states (PASS forwards beats, DISCARD drops
//                    the tail of a truncated frame)
//   len_params_ok  : elaboration-time legality check of the length parameters
package axis_len_check_pkg;

    typedef enum logic [0:0] {
        PASS    = 1'b0,
        DISCARD = 1'b1
    } state_t;

    // Legal when 1 <= min_len <= max_len < 2**len_width, with a counter
    // width the 64-bit limit arithmetic below can represent.
    function automatic bit len_params_ok(input int min_len, input int max_len,
                                         input int len_width);
        longint limit;
        bit     ok;
        if ((len_width < 1) || (len_width > 32)) begin
            ok = 1'b0;
        end else begin
            limit = longint'(64'd1 << len_width);
            ok    = (min_len >= 1) && (min_len <= max_len) &&
                    (longint'(max_len) < limit);
        end
        return ok;
    endfunction

endpackage

// File: rtl/axis_frame_len_check_if.sv
// AXI-Stream bundle with a 1-bit tuser.
//   master : drives tdata/tvalid/tlast/tuser, receives tready
//   slave  : receives tdata/tvalid/tlast/tuser, drives tready
interface axis_frame_len_check_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic                  tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser,
                    input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, input  tuser,
                    output tready);
endinterface

// File: rtl/axis_frame_len_check_out_reg.sv
// Single-stage valid/ready output register carrying {tdata, tlast, tuser}.
// The caller only asserts load when the stage can accept
// (out_ready | ~out_valid), so a held beat is never overwritten.
//   clk, rst     : clock, synchronous active-high reset
//   load         : capture in_data/in_last/in_user this edge
//   in_*         : beat to capture
//   out_ready    : downstream ready
//   out_valid/out_data/out_last/out_user : registered stream outputs
module axis_out_reg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    input  logic                  in_user,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  out_user
);

    logic                  valid_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic                  last_r;
    logic                  user_r;

    // Load a new beat, or drop valid once the held beat has been taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
            data_r  <= {DATA_WIDTH{1'b0}};
            last_r  <= 1'b0;
            user_r  <= 1'b0;
        end else if (load) begin
            valid_r <= 1'b1;
            data_r  <= in_data;
            last_r  <= in_last;
            user_r  <= in_user;
        end else if (out_ready) begin
            valid_r <= 1'b0;
        end
    end

    assign out_valid = valid_r;
    assign out_data  = data_r;
    assign out_last  = last_r;
    assign out_user  = user_r;

endmodule

// File: rtl/axis_frame_len_check.sv
// Frame length checker sitting in front of the frame FIFO. Counts beats per
// frame, flags short frames and frames with an upstream error via tuser on
// the tlast beat, and truncates over-long frames with a forced tlast/tuser
// followed by silent discard of the remainder.
//   clk, rst     : clock, synchronous active-high reset
//   input_axis   : upstream stream (tuser sampled on the tlast beat only)
//   output_axis  : downstream stream (tuser = bad-frame flag, tlast beats only)
//   frame_good   : pulse, frame ended clean
//   frame_short  : pulse, frame ended below MIN_LEN beats
//   frame_long   : pulse, frame truncated at MAX_LEN beats
//   frame_len    : beat count of the last completed or truncated frame
module axis_frame_len_check
    import axis_len_check_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 16,
    parameter int MIN_LEN    = 2,
    parameter int MAX_LEN    = 1518
) (
    input  logic                  clk,
    input  logic                  rst,
    axis_frame_len_check_if.slave  input_axis,
    axis_frame_len_check_if.master output_axis,
    output logic                  frame_good,
    output logic                  frame_short,
    output logic                  frame_long,
    output logic [LEN_WIDTH-1:0]  frame_len
);

    generate
        if (!len_params_ok(MIN_LEN, MAX_LEN, LEN_WIDTH)) begin : g_bad_params
            $error("axis_frame_len_check: illegal MIN_LEN/MAX_LEN/LEN_WIDTH");
        end
    endgenerate

    localparam logic [LEN_WIDTH-1:0] MIN_L = LEN_WIDTH'(MIN_LEN);
    localparam logic [LEN_WIDTH-1:0] MAX_L = LEN_WIDTH'(MAX_LEN);
    localparam logic [LEN_WIDTH-1:0] ONE_L = LEN_WIDTH'(1'b1);
    localparam logic [LEN_WIDTH-1:0] ZERO_L = {LEN_WIDTH{1'b0}};

    state_t                 state_r;
    state_t                 state_next_s;
    logic [LEN_WIDTH-1:0]   cnt_r;
    logic [LEN_WIDTH-1:0]   cnt_d_s;
    logic [LEN_WIDTH-1:0]   cnt_inc_s;
    logic                   in_ready_s;
    logic                   accept_s;
    logic                   load_s;
    logic                   load_last_s;
    logic                   load_user_s;
    logic                   good_d_s;
    logic                   short_d_s;
    logic                   long_d_s;
    logic                   len_we_s;
    logic [LEN_WIDTH-1:0]   len_d_s;
    logic                   out_valid_s;
    logic [DATA_WIDTH-1:0]  out_data_s;
    logic                   out_last_s;
    logic                   out_user_s;
    logic                   good_r;
    logic                   short_r;
    logic                   long_r;
    logic [LEN_WIDTH-1:0]   frame_len_r;

    assign cnt_inc_s = cnt_r + ONE_L;

    // Next state, counter update, output-register load and status decode.
    always_comb begin
        state_next_s = state_r;
        cnt_d_s      = cnt_r;
        in_ready_s   = 1'b0;
        accept_s     = 1'b0;
        load_s       = 1'b0;
        load_last_s  = 1'b0;
        load_user_s  = 1'b0;
        good_d_s     = 1'b0;
        short_d_s    = 1'b0;
        long_d_s     = 1'b0;
        len_we_s     = 1'b0;
        len_d_s      = frame_len_r;
        case (state_r)
            PASS: begin
                in_ready_s = output_axis.tready | ~out_valid_s;
                accept_s   = input_axis.tvalid & in_ready_s;
                if (accept_s) begin
                    load_s = 1'b1;
                    if (input_axis.tlast) begin
                        load_last_s = 1'b1;
                        load_user_s = input_axis.tuser | (cnt_inc_s < MIN_L);
                        len_we_s    = 1'b1;
                        len_d_s     = cnt_inc_s;
                        short_d_s   = (cnt_inc_s < MIN_L);
                        good_d_s    = ~(cnt_inc_s < MIN_L) & ~input_axis.tuser;
                        cnt_d_s     = ZERO_L;
                    end else if (cnt_inc_s == MAX_L) begin
                        // Frame hit MAX_LEN without tlast: close it here as
                        // bad and drop whatever is left of it.
                        load_last_s  = 1'b1;
                        load_user_s  = 1'b1;
                        len_we_s     = 1'b1;
                        len_d_s      = MAX_L;
                        long_d_s     = 1'b1;
                        cnt_d_s      = ZERO_L;
                        state_next_s = DISCARD;
                    end else begin
                        cnt_d_s = cnt_inc_s;
                    end
                end else begin
                    cnt_d_s = cnt_r;
                end
            end
            DISCARD: begin
                // Sink the tail independently of the output side.
                in_ready_s = 1'b1;
                accept_s   = input_axis.tvalid;
                if (accept_s && input_axis.tlast) begin
                    state_next_s = PASS;
                end else begin
                    state_next_s = DISCARD;
                end
            end
            default: begin
                state_next_s = PASS;
                cnt_d_s      = ZERO_L;
            end
        endcase
    end

    // State and beat counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= PASS;
            cnt_r   <= ZERO_L;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_d_s;
        end
    end

    // Status pulses and frame length; pulses line up with the terminating
    // beat appearing in the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            good_r      <= 1'b0;
            short_r     <= 1'b0;
            long_r      <= 1'b0;
            frame_len_r <= ZERO_L;
        end else begin
            good_r  <= good_d_s;
            short_r <= short_d_s;
            long_r  <= long_d_s;
            if (len_we_s) begin
                frame_len_r <= len_d_s;
            end
        end
    end

    axis_out_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (load_s),
        .in_data   (input_axis.tdata),
        .in_last   (load_last_s),
        .in_user   (load_user_s),
        .out_ready (output_axis.tready),
        .out_valid (out_valid_s),
        .out_data  (out_data_s),
        .out_last  (out_last_s),
        .out_user  (out_user_s)
    );

    assign input_axis.tready  = in_ready_s;
    assign output_axis.tvalid = out_valid_s;
    assign output_axis.tdata  = out_data_s;
    assign output_axis.tlast  = out_last_s;
    assign output_axis.tuser  = out_user_s;
    assign frame_good         = good_r;
    assign frame_short        = short_r;
    assign frame_long         = long_r;
    assign frame_len          = frame_len_r;

endmodule

// File: tb/tb_axis_frame_len_check.sv
// Scoreboard bench for axis_frame_len_check (MIN_LEN=2, MAX_LEN=4).
// A frame-level reference model predicts output beats and status pulses;
// a monitor pops and compares them whenever the DUT presents them.
module tb_axis_frame_len_check;

    localparam int DW   = 8;
    localparam int LW   = 16;
    localparam int MINL = 2;
    localparam int MAXL = 4;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
        logic          u;
    } beat_t;

    typedef struct packed {
        logic          g;
        logic          s;
        logic          lg;
        logic [LW-1:0] len;
    } stat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic frame_good, frame_short, frame_long;
    logic [LW-1:0] frame_len;

    axis_frame_len_check_if #(.DATA_WIDTH(DW)) in_if ();
    axis_frame_len_check_if #(.DATA_WIDTH(DW)) out_if ();

    axis_frame_len_check #(
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW),
        .MIN_LEN    (MINL),
        .MAX_LEN    (MAXL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .input_axis  (in_if),
        .output_axis (out_if),
        .frame_good  (frame_good),
        .frame_short (frame_short),
        .frame_long  (frame_long),
        .frame_len   (frame_len)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    beat_t       exp_q[$];
    stat_t       stat_q[$];
    logic [DW-1:0] fdata[$];
    bit          rdy_pat[$];
    bit          mon_en   = 1'b0;
    bit          rand_rdy = 1'b0;
    bit          rand_gap = 1'b0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endfunction

    task automatic ready_loop();
        forever begin
            @(posedge clk);
            #1;
            if (rdy_pat.size() > 0) out_if.tready = rdy_pat.pop_front();
            else if (rand_rdy)      out_if.tready = 1'($urandom_range(0, 1));
            else                    out_if.tready = 1'b1;
        end
    endtask

    task automatic monitor_loop();
        beat_t e;
        stat_t s;
        bit    hp = 1'b0;
        beat_t held;
        forever begin
            @(negedge clk);
            if (mon_en && !rst) begin
                if (hp) chk("stall_stability", 64'({out_if.tvalid, out_if.tdata, out_if.tlast, out_if.tuser}),
                            64'({1'b1, held}));
                if (out_if.tvalid && out_if.tready) begin
                    if (exp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_beat actual=%0h expected=none", out_if.tdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_beat", 64'({out_if.tdata, out_if.tlast, out_if.tuser}), 64'(e));
                    end
                end
                hp   = out_if.tvalid && !out_if.tready;
                held = {out_if.tdata, out_if.tlast, out_if.tuser};
                if (frame_good || frame_short || frame_long) begin
                    if (stat_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_status actual=%0b%0b%0b expected=none",
                                 frame_good, frame_short, frame_long);
                    end else begin
                        s = stat_q.pop_front();
                        chk("status", 64'({frame_good, frame_short, frame_long, frame_len}), 64'(s));
                    end
                end
            end else begin
                hp = 1'b0;
            end
        end
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic drive_beat(input logic [DW-1:0] d, input logic l, input logic u);
        bit ok = 1'b0;
        int t  = 0;
        if (rand_gap) begin
            repeat ($urandom_range(0, 2)) begin
                in_if.tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        in_if.tvalid = 1'b1;
        in_if.tdata  = d;
        in_if.tlast  = l;
        in_if.tuser  = u;
        while (!ok && t < 200) begin
            @(negedge clk);
            ok = in_if.tready;
            @(posedge clk);
            #1;
            t++;
        end
        in_if.tvalid = 1'b0;
        in_if.tlast  = 1'b0;
        in_if.tuser  = 1'b0;
        if (!ok) begin
            checks++; failures++;
            $display("FAIL accept_timeout actual=stalled expected=accepted");
        end
    endtask

    // Reference model at frame level, then drive the frame in fdata.
    task automatic send_frame(input bit err);
        int  n     = fdata.size();
        bit  trunc = (n > MAXL);
        int  nout  = trunc ? MAXL : n;
        bit  last;
        beat_t b;
        stat_t s;
        for (int i = 0; i < nout; i++) begin
            last = (i == nout - 1);
            b.d  = fdata[i];
            b.l  = last;
            b.u  = last ? (trunc ? 1'b1 : (err || (n < MINL))) : 1'b0;
            exp_q.push_back(b);
        end
        if (trunc)          begin s = {1'b0, 1'b0, 1'b1, LW'(MAXL)}; stat_q.push_back(s); end
        else if (n < MINL)  begin s = {1'b0, 1'b1, 1'b0, LW'(n)};    stat_q.push_back(s); end
        else if (!err)      begin s = {1'b1, 1'b0, 1'b0, LW'(n)};    stat_q.push_back(s); end
        for (int i = 0; i < n; i++) begin
            drive_beat(fdata[i], (i == n - 1),
                       (i == n - 1) ? err : 1'($urandom_range(0, 1)));
        end
        fdata.delete();
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() > 0 || stat_q.size() > 0) && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("drain_beats_left", 64'(exp_q.size()), 64'd0);
        chk("drain_status_left", 64'(stat_q.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_tvalid"}, 64'(out_if.tvalid), 64'd0);
        chk({tag, "_tdata"},  64'(out_if.tdata),  64'd0);
        chk({tag, "_tlast"},  64'(out_if.tlast),  64'd0);
        chk({tag, "_tuser"},  64'(out_if.tuser),  64'd0);
        chk({tag, "_pulses"}, 64'({frame_good, frame_short, frame_long}), 64'd0);
        chk({tag, "_len"},    64'(frame_len),     64'd0);
    endtask

    initial begin
        in_if.tvalid  = 1'b0;
        in_if.tdata   = 8'h00;
        in_if.tlast   = 1'b0;
        in_if.tuser   = 1'b0;
        out_if.tready = 1'b1;
        fork
            ready_loop();
            monitor_loop();
        join_none

        repeat (3) @(posedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        // Good 3-beat frame
        fdata = '{8'h11, 8'h22, 8'h33}; send_frame(1'b0);
        // Short 1-beat frame
        fdata = '{8'hAA}; send_frame(1'b0);
        // Long 6-beat frame, then a clean 2-beat frame
        fdata = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}; send_frame(1'b0);
        fdata = '{8'h07, 8'h08}; send_frame(1'b0);
        // Exactly MAX_LEN, then MAX_LEN+1
        fdata = '{8'h41, 8'h42, 8'h43, 8'h44}; send_frame(1'b0);
        fdata = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55}; send_frame(1'b0);
        drain();

        // Backpressure 1,0,0,1 during a 3-beat frame
        rdy_pat.push_back(1'b1); rdy_pat.push_back(1'b0);
        rdy_pat.push_back(1'b0); rdy_pat.push_back(1'b1);
        fdata = '{8'h61, 8'h62, 8'h63}; send_frame(1'b0);
        drain();

        // Upstream error on the last beat
        fdata = '{8'h71, 8'h72, 8'h73}; send_frame(1'b1);
        drain();

        // Reset after two beats of an unfinished frame
        mon_en = 1'b0;
        drive_beat(8'h81, 1'b0, 1'b0);
        drive_beat(8'h82, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("midreset");
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        fdata = '{8'h91, 8'h92}; send_frame(1'b0);
        drain();

        // Randomized frames with random gaps and backpressure
        rand_rdy = 1'b1;
        rand_gap = 1'b1;
        for (int f = 0; f < 80; f++) begin
            int n = $urandom_range(1, 7);
            for (int i = 0; i < n; i++) fdata.push_back(8'($urandom));
            send_frame(($urandom_range(0, 3) == 0));
        end
        rand_rdy = 1'b0;
        rand_gap = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axis_frame_len_check.md
Name: axis_frame_len_check

Overview:
- Single-beat-latency AXI-Stream stage placed directly upstream of the frame FIFO.
- Counts beats per frame and forces the output tuser bad-frame flag on frames shorter than MIN_LEN or carrying an input error.
- Truncates frames longer than MAX_LEN: emits a forced tlast with tuser=1, then silently discards the rest of the frame.
- The downstream FIFO therefore rolls back every flagged frame, so only well-formed frames reach the read side.

Parameters:
- DATA_WIDTH, 8: tdata width.
- LEN_WIDTH, 16: beat counter and frame_len width.
- MIN_LEN, 2: minimum legal frame length in beats. Must be >= 1.
- MAX_LEN, 1518: maximum legal frame length in beats. Must satisfy MIN_LEN <= MAX_LEN < 2**LEN_WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- input_axis_tdata  in  DATA_WIDTH  input data
- input_axis_tvalid  in  1  input valid
- input_axis_tready  out  1  input ready
- input_axis_tlast  in  1  input end of frame
- input_axis_tuser  in  1  upstream error flag, sampled on the tlast beat only
- output_axis_tdata  out  DATA_WIDTH  output data
- output_axis_tvalid  out  1  output valid
- output_axis_tready  in  1  output ready
- output_axis_tlast  out  1  output end of frame (may be forced)
- output_axis_tuser  out  1  bad-frame flag, valid only with tlast
- frame_good  out  1  one-cycle pulse: frame ended clean
- frame_short  out  1  one-cycle pulse: frame ended below MIN_LEN
- frame_long  out  1  one-cycle pulse: frame truncated at MAX_LEN
- frame_len  out  LEN_WIDTH  beat count of the last completed or truncated frame

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. Reset clears:
  - output_axis_tvalid, tdata, tlast, tuser, frame_good/short/long, frame_len, and the beat count;
  - state returns to PASS.
- Reset mid-frame:
  - the partial frame is lost;
  - the next input beat is treated as the start of a new frame.
- Output register:
  - One stage, holding tdata/tlast/tuser/tvalid.
  - In PASS, input_axis_tready = output_axis_tready | ~output_axis_tvalid.
  - An input beat is accepted when input_axis_tvalid & input_axis_tready.
  - An accepted beat is loaded into the output register on the same edge, giving 1-cycle latency.
  - Full throughput: 1 beat/cycle while output_axis_tready=1.
- Output valid update: output_axis_tvalid clears when the held beat is taken and no new beat is loaded. Otherwise it holds.
- Data stability: output data is stable while output_axis_tvalid=1 and output_axis_tready=0.
- Beat count: cnt_next = cnt + 1 on each accepted beat in PASS.
- State PASS, on an accepted beat, exactly one of:
  - tlast=1: output tlast=1, tuser = input_axis_tuser | (cnt_next < MIN_LEN).
    - frame_len <= cnt_next.
    - Pulse frame_short if cnt_next < MIN_LEN, else frame_good if input_axis_tuser=0. An error-only frame pulses neither.
    - cnt <= 0; stay in PASS.
  - tlast=0 and cnt_next == MAX_LEN: output the beat with tlast=1, tuser=1.
    - frame_len <= MAX_LEN; pulse frame_long.
    - cnt <= 0; go to DISCARD.
  - Otherwise: pass the beat with tlast=0, tuser=0; cnt <= cnt_next.
- State DISCARD:
  - input_axis_tready=1 regardless of the output side.
  - Accepted beats are dropped and never loaded into the output register.
  - An accepted beat with tlast=1 returns to PASS. No pulse is generated.
  - A held output beat still drains normally while in DISCARD.
- Boundaries:
  - A frame of exactly MAX_LEN beats ending in tlast is legal: frame_good, no truncation.
  - A single-beat frame with MIN_LEN=1 is good.
  - A frame of exactly MAX_LEN+1 beats truncates; the single remaining beat is discarded.
- Status pulse timing: pulses assert in the cycle after the terminating beat is accepted, coincident with that beat becoming visible on the output. They are high for exactly one cycle.
- Counter cannot overflow: it returns to 0 at MAX_LEN.
- output_axis_tuser is 0 on all non-tlast beats.

Decomposition:
- Package axis_len_check_pkg:
  - state enum {PASS, DISCARD};
  - parameter-legality check function for MIN_LEN/MAX_LEN/LEN_WIDTH.
- One natural sub-module: axis_out_reg, the single-stage valid/ready register carrying {tdata, tlast, tuser}, reusable by other stream stages.
- The FSM and counter stay in the top module.

Test Plan:
- Good frame: MIN_LEN=2, MAX_LEN=4, frame of 3 beats (0x11, 0x22, 0x33 with tlast), tuser=0, output_axis_tready=1.
  -> Same 3 beats appear 1 cycle later, last beat tuser=0.
  -> frame_good one pulse; frame_len=3; no input stall.
- Short frame: 1-beat frame 0xAA with tlast.
  -> Output 0xAA, tlast=1, tuser=1; frame_short pulse; frame_len=1.
- Long frame: 6-beat frame 0x01..0x06.
  -> Output 0x01..0x04 with tlast forced on 0x04, tuser=1; frame_long pulse; frame_len=4.
  -> 0x05 and 0x06 are accepted with tready=1 and never output.
  -> A following 2-beat frame passes clean.
- Exact MAX: 4-beat frame ending in tlast.
  -> Normal pass, tuser=0, frame_good, no discard.
- Backpressure: output_axis_tready toggled 1,0,0,1 during a 3-beat good frame.
  -> Input tready low exactly while the output is held; no beat lost or duplicated; output data stable while stalled.
- Upstream error and reset: 3-beat frame with input tuser=1 on the last beat.
  -> Output tuser=1; no frame_good/short/long pulse.
  -> rst asserted after beat 2 of the next frame: all outputs return to 0; a subsequent 2-beat frame reports frame_len=2.
